emu_host_sequencer: RTL and testbench
=====================================

// Module: emu_host_sequencer
// PURPOSE
//  Upstream driver of the DUT emulation wrapper.
//  - Takes framed stimulus bytes from the host byte link (UART RX side).
//  - Writes them into the wrapper's stimulus array, strobes load, applies one DUT clock pulse, strobes get.
//  - Reads back the captured output vector and returns it byte by byte on the host TX link.
//  - One frame in gives exactly one DUT cycle and one response frame out.
// PARAMETERS
//  NUM_STIM   2  stimulus bytes per frame, 1..8 (fits Addr_emu[2:0])
//  NUM_OUT    3  response bytes per frame, 1..8
//  CLK_HI     2  clk_emu cycles clk_dut is held high, >=1
//  CLK_LO     2  clk_emu cycles clk_dut is held low before get, >=1
// PORTS
//  clk_emu     in   1  emulation clock; sole clock, all logic on posedge
//  rst_emu     in   1  asynchronous active-high reset
//  rx_data     in   8  host byte
//  rx_valid    in   1  rx_data valid
//  rx_ready    out  1  byte accepted when rx_valid & rx_ready
//  tx_data     out  8  response byte to host
//  tx_valid    out  1  tx_data valid, held until tx_ready
//  tx_ready    in   1  host link accepts byte
//  Din_emu     out  8  stimulus byte to wrapper
//  Addr_emu    out  3  wrapper array index
//  load_emu    out  1  1-cycle strobe: wrapper latches stimulus into DUT inputs
//  get_emu     out  1  1-cycle strobe: wrapper captures DUT outputs
//  Dout_emu    in   8  wrapper output byte, registered one clk_emu after Addr_emu
//  clk_dut     out  1  generated DUT clock, glitch-free register output
//  busy        out  1  frame in progress (any state but IDLE)
//  cycle_cnt   out  16 DUT clock pulses issued since reset; wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (async, all outputs registered):
//    - outputs 0: rx_ready, tx_valid, tx_data, Din_emu, Addr_emu, load_emu, get_emu, clk_dut, busy, cycle_cnt.
//    - state=IDLE.
//  - Wrapper idle rule: with load_emu=get_emu=0, every clk_emu edge writes Din_emu into stim[Addr_emu]
//    and registers vect[Addr_emu] onto Dout_emu.
//  - FSM:
//    - IDLE: rx_ready=1. On an accepted byte go to WR.
//    - WR: drive Din_emu=byte, Addr_emu=idx for one cycle (rx_ready=0). idx++.
//      If idx<NUM_STIM go back to RX (rx_ready=1, wait for the next byte), else go to LOAD.
//      RX differs from IDLE only in that busy=1.
//    - LOAD: load_emu=1 for exactly one cycle.
//    - HI: clk_dut=1 for CLK_HI cycles. cycle_cnt++ on entry.
//    - LO: clk_dut=0 for CLK_LO cycles.
//    - GET: get_emu=1 for exactly one cycle. idx=0.
//    - RA: Addr_emu=idx.
//    - RW: wait one cycle.
//    - RC: capture Dout_emu into tx_data, tx_valid=1.
//    - TX: hold tx_data/tx_valid until tx_ready. Then idx++. If idx<NUM_OUT go to RA, else go to IDLE.
//  - Strobes: load_emu and get_emu are never both high. They are never high while Addr_emu/Din_emu change.
//  - Readback hazard: during RA/RW/RC, Din_emu holds the last stimulus byte. The resulting wrapper stim write is harmless.
//  - rx_ready=0 in every state except IDLE/RX. Bytes are backpressured, never dropped.
//  - Minimum frame latency, last rx byte accepted -> first tx_valid: 1 + 1 + CLK_HI + CLK_LO + 1 + 3 cycles.
//  - tx stall: tx_ready low for any duration. tx_data stays stable, FSM waits, clk_dut stays 0.
//  - Reset mid-frame: partial frame discarded. clk_dut forced 0 at once, with no runt high pulse after release.
//  - idx is 3 bits plus a terminal compare. Parameter values above 8 are illegal; the elaboration check fails.
// STRUCTURE
//  - Shared include emu_defs.vh:
//    - state encodings.
//    - EMU_ADDR_W=3, EMU_DATA_W=8 (also used by the wrapper).
//  - One sub-module, emu_clk_pulse: CLK_HI/CLK_LO down-counter producing the clk_dut pulse and a done flag.
//  - Remaining logic (FSM, idx, tx register, cycle_cnt) is flat in this module.
// TESTING
//  1. Frame 0x05,0x0B.
//     -> wrapper writes addr0=0x05, then addr1=0x0B.
//     -> one load pulse, then clk_dut high 2 cycles, low 2, then one get pulse.
//  2. Bench model vect={0x12,0x34,0x01}, tx_ready=1.
//     -> tx bytes 0x12,0x34,0x01 in order; busy drops after the last byte; cycle_cnt=1.
//  3. tx_ready held 0 for 10 cycles on byte 2.
//     -> tx_data=0x34 stable; no extra clk_dut edge; resumes cleanly.
//  4. rx_valid asserted continuously during HI/LO/TX.
//     -> rx_ready=0; no byte consumed; next frame starts only after IDLE.
//  5. rst_emu pulsed while clk_dut=1 mid-HI.
//     -> clk_dut=0 asynchronously; all outputs 0.
//     -> a new frame 0x00,0x08 then runs normally.
//  6. Preload cycle_cnt=0xFFFF by forcing it, then one frame.
//     -> cycle_cnt=0x0000.

Source files
------------

// File: rtl/emu_host_sequencer_pkg.sv
// Shared widths and FSM encoding for the emulation host sequencer and its wrapper.
package emu_host_sequencer_pkg;
  localparam int EMU_ADDR_W = 3;
  localparam int EMU_DATA_W = 8;
  localparam int CNT_W      = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_RX, S_WR, S_LOAD, S_HI, S_LO, S_GET, S_RA, S_RW, S_RC, S_TX
  } state_t;

  // Terminal index for a 1..8 element count held in a 3-bit index.
  function automatic logic [EMU_ADDR_W-1:0] last_idx(input int n);
    return EMU_ADDR_W'(n - 1);
  endfunction
endpackage

// File: rtl/emu_host_sequencer_if.sv
// Host byte link plus emulation-wrapper bus; master is the sequencer side.
interface emu_host_sequencer_if;
  import emu_host_sequencer_pkg::*;
  logic [EMU_DATA_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [EMU_DATA_W-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [EMU_DATA_W-1:0] Din_emu;
  logic [EMU_ADDR_W-1:0] Addr_emu;
  logic                  load_emu;
  logic                  get_emu;
  logic [EMU_DATA_W-1:0] Dout_emu;
  logic                  clk_dut;
  logic                  busy;
  logic [CNT_W-1:0]      cycle_cnt;

  modport master (
    input  rx_data, rx_valid, tx_ready, Dout_emu,
    output rx_ready, tx_data, tx_valid, Din_emu, Addr_emu, load_emu, get_emu,
           clk_dut, busy, cycle_cnt
  );
  modport slave (
    output rx_data, rx_valid, tx_ready, Dout_emu,
    input  rx_ready, tx_data, tx_valid, Din_emu, Addr_emu, load_emu, get_emu,
           clk_dut, busy, cycle_cnt
  );
endinterface

// File: rtl/emu_host_sequencer_clk_pulse.sv
// One DUT clock pulse per start: CLK_HI cycles high then CLK_LO cycles low.
module emu_host_sequencer_clk_pulse #(
  parameter int CLK_HI = 2,
  parameter int CLK_LO = 2
) (
  input  logic clk_emu,
  input  logic rst_emu,
  input  logic i_start,
  output logic o_clk_dut,
  output logic o_hi_end,
  output logic o_lo_end
);
  localparam int CMAX = (CLK_HI > CLK_LO) ? CLK_HI : CLK_LO;
  localparam int CW   = $clog2(CMAX + 1);

  logic          r_hi;
  logic          r_lo;
  logic [CW-1:0] r_cnt;

  // r_hi drives clk_dut directly so the pulse is a clean register output.
  always_ff @(posedge clk_emu or posedge rst_emu) begin
    if (rst_emu) begin
      r_hi  <= 1'b0;
      r_lo  <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_hi  <= 1'b1;
      r_lo  <= 1'b0;
      r_cnt <= CW'(CLK_HI - 1);
    end else if (r_hi) begin
      if (r_cnt == '0) begin
        r_hi  <= 1'b0;
        r_lo  <= 1'b1;
        r_cnt <= CW'(CLK_LO - 1);
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else if (r_lo) begin
      if (r_cnt == '0) r_lo  <= 1'b0;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_clk_dut = r_hi;
  assign o_hi_end  = r_hi && (r_cnt == '0);
  assign o_lo_end  = r_lo && (r_cnt == '0);
endmodule

// File: rtl/emu_host_sequencer.sv
// Host frame -> wrapper stimulus writes, load, one DUT clock, get, readback -> host response frame.
module emu_host_sequencer
  import emu_host_sequencer_pkg::*;
#(
  parameter int NUM_STIM = 2,
  parameter int NUM_OUT  = 3,
  parameter int CLK_HI   = 2,
  parameter int CLK_LO   = 2
) (
  input  logic                 clk_emu,
  input  logic                 rst_emu,
  emu_host_sequencer_if.master bus
);
  if (NUM_STIM < 1 || NUM_STIM > 8 || NUM_OUT < 1 || NUM_OUT > 8 ||
      CLK_HI < 1 || CLK_LO < 1) begin : g_param_chk
    $error("emu_host_sequencer: illegal parameter value");
  end

  state_t                r_state, w_state;
  logic [EMU_ADDR_W-1:0] r_idx, w_idx;
  logic [EMU_ADDR_W-1:0] r_addr, w_addr;
  logic [EMU_DATA_W-1:0] r_din, w_din;
  logic [EMU_DATA_W-1:0] r_tx_data, w_tx_data;
  logic                  r_tx_valid, w_tx_valid;
  logic                  r_rx_ready, w_rx_ready;
  logic                  r_load, w_load;
  logic                  r_get, w_get;
  logic                  r_busy;
  logic [CNT_W-1:0]      r_cycle_cnt, w_cycle_cnt;
  logic                  w_accept, w_hi_end, w_lo_end, w_clk_dut;

  assign w_accept = bus.rx_valid && r_rx_ready;

  emu_host_sequencer_clk_pulse #(.CLK_HI(CLK_HI), .CLK_LO(CLK_LO)) u_pulse (
    .clk_emu   (clk_emu),
    .rst_emu   (rst_emu),
    .i_start   (r_state == S_LOAD),
    .o_clk_dut (w_clk_dut),
    .o_hi_end  (w_hi_end),
    .o_lo_end  (w_lo_end)
  );

  always_ff @(posedge clk_emu or posedge rst_emu) begin
    if (rst_emu) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_addr      <= '0;
      r_din       <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_rx_ready  <= 1'b0;
      r_load      <= 1'b0;
      r_get       <= 1'b0;
      r_busy      <= 1'b0;
      r_cycle_cnt <= '0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_addr      <= w_addr;
      r_din       <= w_din;
      r_tx_data   <= w_tx_data;
      r_tx_valid  <= w_tx_valid;
      r_rx_ready  <= w_rx_ready;
      r_load      <= w_load;
      r_get       <= w_get;
      r_busy      <= (w_state != S_IDLE);
      r_cycle_cnt <= w_cycle_cnt;
    end
  end

  // Outputs are registered from next-state values so every strobe lands on its state's cycle.
  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_addr      = r_addr;
    w_din       = r_din;
    w_tx_data   = r_tx_data;
    w_tx_valid  = r_tx_valid;
    w_rx_ready  = 1'b0;
    w_load      = 1'b0;
    w_get       = 1'b0;
    w_cycle_cnt = r_cycle_cnt;
    case (r_state)
      S_IDLE, S_RX: begin
        if (w_accept) begin
          w_state = S_WR;
          w_din   = bus.rx_data;
          w_addr  = r_idx;
        end else begin
          w_rx_ready = 1'b1;
        end
      end
      S_WR: begin
        if (r_idx == last_idx(NUM_STIM)) begin
          w_state = S_LOAD;
          w_load  = 1'b1;
          w_idx   = '0;
        end else begin
          w_state    = S_RX;
          w_rx_ready = 1'b1;
          w_idx      = r_idx + 1'b1;
        end
      end
      S_LOAD: begin
        w_state     = S_HI;
        w_cycle_cnt = r_cycle_cnt + 1'b1;
      end
      S_HI: if (w_hi_end) w_state = S_LO;
      S_LO: begin
        if (w_lo_end) begin
          w_state = S_GET;
          w_get   = 1'b1;
        end
      end
      S_GET: begin
        w_state = S_RA;
        w_idx   = '0;
        w_addr  = '0;
      end
      S_RA: w_state = S_RW;
      // Dout_emu is registered one cycle after Addr_emu, so RW absorbs that delay.
      S_RW: w_state = S_RC;
      S_RC: begin
        w_state    = S_TX;
        w_tx_data  = bus.Dout_emu;
        w_tx_valid = 1'b1;
      end
      S_TX: begin
        if (bus.tx_ready) begin
          w_tx_valid = 1'b0;
          if (r_idx == last_idx(NUM_OUT)) begin
            w_state    = S_IDLE;
            w_idx      = '0;
            w_rx_ready = 1'b1;
          end else begin
            w_state = S_RA;
            w_idx   = r_idx + 1'b1;
            w_addr  = r_idx + 1'b1;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign bus.rx_ready  = r_rx_ready;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.Din_emu   = r_din;
  assign bus.Addr_emu  = r_addr;
  assign bus.load_emu  = r_load;
  assign bus.get_emu   = r_get;
  assign bus.clk_dut   = w_clk_dut;
  assign bus.busy      = r_busy;
  assign bus.cycle_cnt = r_cycle_cnt;
endmodule

// File: tb/tb_emu_host_sequencer.sv
// Bench: wrapper model, table of directed frames, random frames, reset and wrap sequences.
module tb_emu_host_sequencer;
  localparam int NS  = 2;
  localparam int NO  = 3;
  localparam int HI  = 2;
  localparam int LO  = 2;
  localparam int LAT = 1 + 1 + HI + LO + 1 + 3;
  localparam int SW  = NS * 8;
  localparam int VW  = NO * 8;

  logic clk_emu = 1'b0;
  logic rst_emu = 1'b1;

  emu_host_sequencer_if bus();

  emu_host_sequencer #(.NUM_STIM(NS), .NUM_OUT(NO), .CLK_HI(HI), .CLK_LO(LO)) dut (
    .clk_emu (clk_emu),
    .rst_emu (rst_emu),
    .bus     (bus)
  );

  always #5 clk_emu = ~clk_emu;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk_emu) cyc <= cyc + 1;

  // Wrapper model: idle edges write stim and register readback; get captures the DUT's outputs.
  logic [7:0] stim [8];
  logic [7:0] vect [8];
  logic [7:0] next_vect [8];
  logic [7:0] dout = 8'h00;
  always @(posedge clk_emu) begin
    if (bus.get_emu) begin
      for (int i = 0; i < 8; i++) vect[i] <= next_vect[i];
    end else if (!bus.load_emu) begin
      stim[bus.Addr_emu] <= bus.Din_emu;
      dout <= vect[bus.Addr_emu];
    end
  end
  assign bus.Dout_emu = dout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor state
  logic [NS-1:0][7:0] cur_stim;
  logic prev_clk = 1'b0;
  bit   in_lo = 1'b0, in_back = 1'b0;
  int   hi_run = 0, lo_run = 0, pulses = 0, accepts = 0;

  initial begin
    forever begin
      @(negedge clk_emu);
      #1;
      if (rst_emu) begin
        prev_clk = 1'b0; hi_run = 0; lo_run = 0; in_lo = 1'b0; in_back = 1'b0;
      end else begin
        if (bus.rx_valid && bus.rx_ready) accepts++;
        if (bus.load_emu) begin
          chk("strobe_excl", {31'd0, bus.get_emu}, 32'd0);
          for (int i = 0; i < NS; i++) chk("stim_write", {24'd0, stim[i]}, {24'd0, cur_stim[i]});
          in_back = 1'b1;
        end
        if (in_back && bus.busy) chk("rx_blocked", {31'd0, bus.rx_ready}, 32'd0);
        else if (!bus.busy) in_back = 1'b0;
        if (bus.clk_dut) begin
          if (!prev_clk) begin pulses++; hi_run = 0; in_lo = 1'b0; end
          hi_run++;
        end else if (prev_clk) begin
          chk("clk_hi_len", hi_run, HI);
          lo_run = 1; in_lo = 1'b1;
        end else if (bus.get_emu) begin
          chk("clk_lo_len", lo_run, LO);
          in_lo = 1'b0;
        end else if (in_lo) begin
          lo_run++;
        end
        prev_clk = bus.clk_dut;
      end
    end
  end

  int last_acc = 0;
  int model_pulses = 0, model_acc = 0;
  logic [15:0] model_cnt = 16'd0;

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && t < 200) begin @(negedge clk_emu); t++; end
    chk("rx_accept", {31'd0, bus.rx_ready}, 32'd1);
    last_acc = cyc + 1;
    @(negedge clk_emu);
    bus.rx_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 0);
    chk({tag, "_tx_valid"}, {31'd0, bus.tx_valid}, 0);
    chk({tag, "_tx_data"},  {24'd0, bus.tx_data}, 0);
    chk({tag, "_din"},      {24'd0, bus.Din_emu}, 0);
    chk({tag, "_addr"},     {29'd0, bus.Addr_emu}, 0);
    chk({tag, "_load"},     {31'd0, bus.load_emu}, 0);
    chk({tag, "_get"},      {31'd0, bus.get_emu}, 0);
    chk({tag, "_clk_dut"},  {31'd0, bus.clk_dut}, 0);
    chk({tag, "_busy"},     {31'd0, bus.busy}, 0);
    chk({tag, "_cycle_cnt"}, {16'd0, bus.cycle_cnt}, 0);
  endtask

  task automatic run_frame(input logic [NS-1:0][7:0] s, input logic [NO-1:0][7:0] v,
                           input int stall_idx, input int stall_len, input bit skip_first,
                           input bit hold, input logic [7:0] hold_byte, input logic [15:0] exp_cnt);
    int t;
    cur_stim = s;
    for (int i = 0; i < NO; i++) next_vect[i] = v[i];
    for (int i = 0; i < NS; i++) begin
      if (i == 0 && skip_first) begin
        chk("held_accept", {31'd0, bus.rx_ready}, 32'd1);
        last_acc = cyc + 1;
        @(negedge clk_emu);
        bus.rx_valid = 1'b0;
      end else begin
        send_byte(s[i]);
      end
    end
    if (hold) begin bus.rx_valid = 1'b1; bus.rx_data = hold_byte; end
    model_acc += NS;
    model_pulses++;
    for (int j = 0; j < NO; j++) begin
      bus.tx_ready = !(j == stall_idx && stall_len > 0);
      t = 0;
      while (!bus.tx_valid && t < 200) begin @(negedge clk_emu); t++; end
      chk("tx_valid_seen", {31'd0, bus.tx_valid}, 32'd1);
      if (j == 0) chk("latency", cyc - last_acc, LAT);
      if (!bus.tx_ready) begin
        repeat (stall_len) begin
          chk("stall_valid", {31'd0, bus.tx_valid}, 32'd1);
          chk("stall_data", {24'd0, bus.tx_data}, {24'd0, v[j]});
          chk("stall_clk", {31'd0, bus.clk_dut}, 32'd0);
          @(negedge clk_emu);
        end
        bus.tx_ready = 1'b1;
      end
      chk("tx_byte", {24'd0, bus.tx_data}, {24'd0, v[j]});
      @(negedge clk_emu);
    end
    chk("busy_end", {31'd0, bus.busy}, 32'd0);
    chk("tx_valid_end", {31'd0, bus.tx_valid}, 32'd0);
    chk("cycle_cnt", {16'd0, bus.cycle_cnt}, {16'd0, exp_cnt});
    chk("pulse_count", pulses, model_pulses);
    chk("accept_count", accepts, model_acc);
  endtask

  typedef struct {
    logic [NS-1:0][7:0] s;
    logic [NO-1:0][7:0] v;
    int                 stall_idx;
    int                 stall_len;
    bit                 hold;
    logic [15:0]        exp_cnt;
  } vec_t;
  vec_t tbl [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NS-1:0][7:0] rs, rs_next;
    logic [NO-1:0][7:0] rv;
    logic [7:0] hb;
    bit skip, hold;
    int t;

    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin stim[i] = 8'h00; vect[i] = 8'h00; next_vect[i] = 8'h00; end

    tbl[0] = '{{8'h0B, 8'h05}, {8'h01, 8'h34, 8'h12}, -1, 0,  1'b0, 16'd1};
    tbl[1] = '{{8'h5A, 8'hA5}, {8'h01, 8'h34, 8'h12},  1, 10, 1'b0, 16'd2};
    tbl[2] = '{{8'h00, 8'hFF}, {8'hC3, 8'h55, 8'hAA},  0, 3,  1'b1, 16'd3};
    tbl[3] = '{{8'hC3, 8'h3C}, {8'h80, 8'hFF, 8'h00},  2, 1,  1'b0, 16'd4};

    repeat (3) @(negedge clk_emu);
    chk_reset("reset");
    #2 rst_emu = 1'b0;
    @(negedge clk_emu);

    for (int i = 0; i < 4; i++) begin
      hb = (i < 3) ? tbl[i+1].s[0] : 8'h00;
      run_frame(tbl[i].s, tbl[i].v, tbl[i].stall_idx, tbl[i].stall_len,
                (i > 0) && tbl[i-1].hold, tbl[i].hold, hb, tbl[i].exp_cnt);
    end
    model_cnt = 16'd4;

    skip = 1'b0;
    rs = SW'($urandom);
    for (int r = 0; r < 24; r++) begin
      rs_next = SW'($urandom);
      rv      = VW'($urandom);
      hold    = (r < 23) && ($urandom_range(0, 2) == 0);
      model_cnt = model_cnt + 16'd1;
      run_frame(rs, rv, $urandom_range(0, NO), $urandom_range(1, 6), skip, hold,
                rs_next[0], model_cnt);
      skip = hold;
      rs   = rs_next;
    end

    // Reset in the middle of the DUT clock high phase.
    cur_stim = {8'h88, 8'h77};
    send_byte(8'h77);
    send_byte(8'h88);
    model_acc += NS;
    t = 0;
    while (!bus.clk_dut && t < 50) begin @(negedge clk_emu); t++; end
    chk("pulse_started", {31'd0, bus.clk_dut}, 32'd1);
    model_pulses++;
    #2 rst_emu = 1'b1;
    #1 chk_reset("midhi");
    @(negedge clk_emu);
    #2 rst_emu = 1'b0;
    repeat (6) begin
      @(negedge clk_emu);
      chk("no_runt", {31'd0, bus.clk_dut}, 32'd0);
      chk("idle_after_rst", {31'd0, bus.busy}, 32'd0);
    end
    model_cnt = 16'd1;
    run_frame({8'h08, 8'h00}, {8'h5C, 8'hE7, 8'h9D}, -1, 0, 1'b0, 1'b0, 8'h00, model_cnt);

    // Counter wrap.
    force dut.r_cycle_cnt = 16'hFFFF;
    repeat (2) @(negedge clk_emu);
    release dut.r_cycle_cnt;
    @(negedge clk_emu);
    chk("cnt_preload", {16'd0, bus.cycle_cnt}, 32'h0000FFFF);
    model_cnt = 16'hFFFF;
    model_cnt = model_cnt + 16'd1;
    run_frame({8'h22, 8'h11}, {8'h66, 8'h55, 8'h44}, -1, 0, 1'b0, 1'b0, 8'h00, model_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
